restoring_divider: RTL and testbench

//  Multi-cycle unsigned restoring divider: s-style outputs q = a / b, r = a % b.

---
 rtl/restoring_divider.sv | 128 ++++++++++++
 tb/tb_restoring_divider.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module      : restoring_divider
//  Description : Multi-cycle unsigned restoring divider, q = a / b, r = a % b,
//                one trial subtraction per clock through a full-adder ripple.
//  Revision    : 1.0 - initial release
// ============================================================================
module restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             dbz
);

    localparam int         c_CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div;
    logic [WIDTH-1:0]   r_rem;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_dbz_pend;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_r;
    logic               r_done;
    logic               r_dbz;

    logic [WIDTH:0]     w_rs;
    logic [WIDTH:0]     w_opb;
    logic [WIDTH+1:0]   w_carry;
    logic [WIDTH-1:0]   w_sum;
    logic               w_noborrow;
    logic [WIDTH-1:0]   w_quo_next;

    // Trial subtract Rs - D as Rs + ~{0,D} + 1; carry-out set means no borrow.
    assign w_rs       = {r_rem, r_quo[WIDTH-1]};
    assign w_opb      = {1'b1, ~r_div};
    assign w_carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_fa
            assign w_carry[gi+1] = (w_rs[gi] & w_opb[gi]) |
                                   (w_carry[gi] & (w_rs[gi] ^ w_opb[gi]));
            if (gi < WIDTH) begin : g_sum
                assign w_sum[gi] = w_rs[gi] ^ w_opb[gi] ^ w_carry[gi];
            end
        end
    endgenerate

    assign w_noborrow = w_carry[WIDTH+1];

    always_comb begin
        w_quo_next    = r_quo << 1;
        w_quo_next[0] = w_noborrow;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_quo      <= '0;
            r_div      <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_dbz_pend <= 1'b0;
            r_q        <= '0;
            r_r        <= '0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        if (b != '0) begin
                            r_quo      <= a;
                            r_div      <= b;
                            r_rem      <= '0;
                            r_cnt      <= c_CNT_W'(WIDTH - 1);
                            r_dbz_pend <= 1'b0;
                            r_state    <= c_ST_RUN;
                        end else begin
                            r_quo      <= '1;
                            r_rem      <= a;
                            r_dbz_pend <= 1'b1;
                            r_state    <= c_ST_DONE;
                        end
                    end
                end
                c_ST_RUN: begin
                    r_quo <= w_quo_next;
                    r_rem <= w_noborrow ? w_sum : w_rs[WIDTH-1:0];
                    if (r_cnt == '0) begin
                        r_state <= c_ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_ST_DONE: begin
                    r_done  <= 1'b1;
                    r_q     <= r_quo;
                    r_r     <= r_rem;
                    r_dbz   <= r_dbz_pend;
                    r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign busy = (r_state == c_ST_RUN) || (r_state == c_ST_DONE);
    assign done = r_done;
    assign q    = r_q;
    assign r    = r_r;
    assign dbz  = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_restoring_divider
//  Description : Directed and sweep checks of restoring_divider at WIDTH=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_restoring_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       busy;
    logic       done;
    logic       dbz;

    int n_pass  = 0;
    int n_total = 0;

    restoring_divider #(.WIDTH(4)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        else
            n_pass++;
    endtask

    // Issue one operation and compare latency and results; returns right after
    // the done edge so the next call starts back-to-back.
    task automatic do_op(input logic [3:0] ta, input logic [3:0] tb_v,
                         input logic [3:0] eq, input logic [3:0] er,
                         input logic edbz, input int elat, input string tag);
        int lat;
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = ~ta; b = ~tb_v;
        check({tag, ".busy"}, busy, 1'b1);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".lat"}, lat, elat);
        check({tag, ".q"},   q,   eq);
        check({tag, ".r"},   r,   er);
        check({tag, ".dbz"}, dbz, edbz);
    endtask

    initial begin
        int lat;
        logic saw_done;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.q", q, 0);
        check("rst.r", r, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.dbz", dbz, 0);
        @(negedge clk); rst = 1'b0;

        do_op(4'd13, 4'd3,  4'd4,  4'd1, 1'b0, 5, "13/3");
        @(posedge clk); #1;
        check("13/3.pulse", done, 0);
        check("13/3.hold_q", q, 4);
        check("13/3.idle", busy, 0);
        do_op(4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 5, "15/1");
        do_op(4'd7,  4'd13, 4'd0,  4'd7, 1'b0, 5, "7/13");
        do_op(4'd0,  4'd5,  4'd0,  4'd0, 1'b0, 5, "0/5");
        do_op(4'd9,  4'd0,  4'd15, 4'd9, 1'b1, 1, "9/0");
        do_op(4'd9,  4'd3,  4'd3,  4'd0, 1'b0, 5, "9/3");

        // start held high through RUN with different operands must be ignored
        @(negedge clk);
        a = 4'd13; b = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        a = 4'd2; b = 4'd1;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check("hold.lat", lat, 5);
        check("hold.q", q, 4);
        check("hold.r", r, 1);
        @(posedge clk); #1;
        check("hold.idle", busy, 0);

        // reset two edges into an operation aborts it
        @(negedge clk);
        a = 4'd13; b = 4'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("abort.q", q, 0);
        check("abort.r", r, 0);
        check("abort.busy", busy, 0);
        check("abort.done", done, 0);
        @(negedge clk); rst = 1'b0;
        saw_done = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("abort.nodone", saw_done, 0);
        do_op(4'd14, 4'd4, 4'd3, 4'd2, 1'b0, 5, "14/4");

        // full back-to-back sweep against arithmetic reference
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                if (ib == 0)
                    do_op(4'(ia), 4'd0, 4'd15, 4'(ia), 1'b1, 1, "sweep0");
                else
                    do_op(4'(ia), 4'(ib), 4'(ia / ib), 4'(ia % ib), 1'b0, 5, "sweep");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
